// File: rtl/change_dispenser.sv
// Payout stage of the vending controller: runs the goods motor, then pays change as
// two-unit and one-unit coins over req/ack handshakes, each guarded by an ack timeout.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       goods,
  input  logic [2:0] change,
  input  logic       vend_ack,
  input  logic       coin_two_ack,
  input  logic       coin_one_ack,
  input  logic       two_empty,
  input  logic       one_empty,
  input  logic       fault_clr,
  output logic       vend_req,
  output logic       coin_two_req,
  output logic       coin_one_req,
  output logic       busy,
  output logic       done,
  output logic       drop,
  output logic       fault,
  output logic [2:0] change_left
);

  typedef enum logic [2:0] {
    IDLE,
    VEND_WAIT,
    PAY_SEL,
    TWO_WAIT,
    ONE_WAIT,
    DONE_S,
    FAULT_S
  } state_t;

  // Last wait cycle allowed without ack; reaching it without ack trips FAULT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       left;
  logic             drop_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      left   <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= goods && (state != IDLE);
      case (state)
        IDLE: begin
          if (goods) begin
            left  <= change;
            cnt   <= '0;
            state <= VEND_WAIT;
          end
        end
        VEND_WAIT: begin
          if (vend_ack)             state <= PAY_SEL;
          else if (cnt == CNT_LAST) state <= FAULT_S;
          else                      cnt   <= cnt + 1'b1;
        end
        PAY_SEL: begin
          // Empty flags are looked at only here, so an in-flight handshake always completes.
          cnt <= '0;
          if (left == 3'd0)                         state <= DONE_S;
          else if (left >= 3'd2 && !two_empty)      state <= TWO_WAIT;
          else if (!one_empty)                      state <= ONE_WAIT;
          else                                      state <= FAULT_S;
        end
        TWO_WAIT: begin
          if (coin_two_ack) begin
            left  <= left - 3'd2;
            state <= PAY_SEL;
          end else if (cnt == CNT_LAST) begin
            state <= FAULT_S;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ONE_WAIT: begin
          if (coin_one_ack) begin
            left  <= left - 3'd1;
            state <= PAY_SEL;
          end else if (cnt == CNT_LAST) begin
            state <= FAULT_S;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE_S: state <= IDLE;
        FAULT_S: begin
          if (fault_clr) begin
            left  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register only, so no input reaches an output combinationally.
  assign vend_req     = (state == VEND_WAIT);
  assign coin_two_req = (state == TWO_WAIT);
  assign coin_one_req = (state == ONE_WAIT);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE_S);
  assign fault        = (state == FAULT_S);
  assign drop         = drop_q;
  assign change_left  = left;

endmodule
